// File: rtl/pulse_gen_pkg.sv
// ============================================================================
// Module      : pulse_gen_pkg
// Description : Shared FSM state encoding and clamp limits for pulse_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_gen_pkg;

  // Pulse-train phases: waiting, driving the active level, driving the gap
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    INACTIVE = 2'd2
  } state_e;

  // Two consecutive active samples are needed downstream to see a rising edge
  localparam int unsigned MIN_WIDTH = 2;
  // At least one inactive cycle separates consecutive pulses
  localparam int unsigned MIN_GAP   = 1;

endpackage : pulse_gen_pkg

`default_nettype wire

// File: rtl/pulse_gen_trig_sync.sv
// ============================================================================
// Module      : pulse_gen_trig_sync
// Description : Two-flop synchronizer for an asynchronous trigger pin
//               followed by a registered rising-edge detector. Produces a
//               single-cycle strobe per low-to-high transition of the pin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_gen_trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_async,
  output logic trig_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;

  // Next-state of the synchronizer chain and edge detector
  always_comb begin
    meta_d = trig_async;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
  end

  // Synchronizer, history and edge-strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign trig_rise = rise_q;

endmodule : pulse_gen_trig_sync

`default_nettype wire

// File: rtl/pulse_gen.sv
// ============================================================================
// Module      : pulse_gen
// Description : Programmable pulse-train generator. Latches width, period,
//               pulse count and idle level on start, then emits the train on
//               io_pulsePort with progress count, busy and done reporting.
//               Optional macro PULSE_GEN_EXT_TRIG_EN adds an asynchronous
//               external trigger input (io_extTrig) that acts as io_start.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 io_clk,
  input  logic                 io_rstn,
  input  logic                 io_start,
  input  logic                 io_stop,
  input  logic                 io_defaultLevel_Pulse,
  input  logic [CNT_WIDTH-1:0] io_pulseWidth,
  input  logic [CNT_WIDTH-1:0] io_pulsePeriod,
  input  logic [CNT_WIDTH-1:0] io_pulseNum,
`ifdef PULSE_GEN_EXT_TRIG_EN
  input  logic                 io_extTrig,
`endif
  output logic                 io_pulsePort,
  output logic                 io_busy,
  output logic                 io_done,
  output logic [CNT_WIDTH-1:0] io_pulseCnt
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] width_q, width_d;       // latched active length
  logic [CNT_WIDTH-1:0] gap_q, gap_d;           // latched inactive length
  logic [CNT_WIDTH-1:0] num_q, num_d;           // latched pulse count, 0 = endless
  logic                 def_q, def_d;           // latched idle level
  logic [CNT_WIDTH-1:0] act_cnt_q, act_cnt_d;   // active cycles left, incl. current
  logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;   // inactive cycles left, incl. current
  logic [CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start_req;
  logic [CNT_WIDTH-1:0] width_clamp;
  logic                 period_short;
  logic [CNT_WIDTH-1:0] gap_clamp;
  logic                 last_pulse;
  logic [CNT_WIDTH-1:0] pulse_cnt_inc;

`ifdef PULSE_GEN_EXT_TRIG_EN
  logic trig_rise;

  // A trigger edge during cycle c shows on io_pulsePort in cycle c+4:
  // two synchronizer stages, one edge-detect stage, one FSM stage.
  pulse_gen_trig_sync u_trig_sync (
    .clk        (io_clk),
    .rst_n      (io_rstn),
    .trig_async (io_extTrig),
    .trig_rise  (trig_rise)
  );

  assign start_req = io_start | trig_rise;
`else
  assign start_req = io_start;
`endif

  // Config clamping: the period is turned into a gap length here so the
  // FSM only ever counts down two independent phase lengths. The compare is
  // done one bit wider so a width of all-ones cannot wrap width+1.
  always_comb begin
    width_clamp  = (io_pulseWidth < CNT_WIDTH'(MIN_WIDTH)) ? CNT_WIDTH'(MIN_WIDTH)
                                                           : io_pulseWidth;
    period_short = ({1'b0, io_pulsePeriod} <
                    ({1'b0, width_clamp} + (CNT_WIDTH+1)'(MIN_GAP)));
    gap_clamp    = period_short ? CNT_WIDTH'(MIN_GAP) : (io_pulsePeriod - width_clamp);
  end

  // Completion test and saturating pulse-count increment
  always_comb begin
    last_pulse    = (num_q != '0) && (pulse_cnt_q == num_q);
    pulse_cnt_inc = (pulse_cnt_q == '1) ? pulse_cnt_q : (pulse_cnt_q + CNT_WIDTH'(1));
  end

  // Next-state and output logic. io_pulsePort is registered, so pulse_d is
  // the level for the following cycle. On the final pulse the FSM returns to
  // IDLE at the edge that opens the last inactive cycle, so done and the
  // busy drop appear in that cycle while the line still shows the gap level.
  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    gap_d       = gap_q;
    num_d       = num_q;
    def_d       = def_q;
    act_cnt_d   = act_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    pulse_d     = pulse_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        pulse_d = io_defaultLevel_Pulse;
        busy_d  = 1'b0;
        if (start_req && !io_stop) begin
          width_d     = width_clamp;
          gap_d       = gap_clamp;
          num_d       = io_pulseNum;
          def_d       = io_defaultLevel_Pulse;
          act_cnt_d   = width_clamp;
          // Count is cleared and the first pulse counted in the same step
          pulse_cnt_d = CNT_WIDTH'(1);
          pulse_d     = ~io_defaultLevel_Pulse;
          busy_d      = 1'b1;
          state_d     = ACTIVE;
        end
      end

      ACTIVE: begin
        if (io_stop) begin
          pulse_d = def_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (act_cnt_q == CNT_WIDTH'(1)) begin
          pulse_d = def_q;
          if (last_pulse && (gap_q == CNT_WIDTH'(1))) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_q;
            state_d   = INACTIVE;
          end
        end else begin
          act_cnt_d = act_cnt_q - CNT_WIDTH'(1);
          pulse_d   = ~def_q;
        end
      end

      INACTIVE: begin
        if (io_stop) begin
          pulse_d = def_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (last_pulse && (gap_cnt_q == CNT_WIDTH'(2))) begin
          pulse_d = def_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (gap_cnt_q == CNT_WIDTH'(1)) begin
          act_cnt_d   = width_q;
          pulse_cnt_d = pulse_cnt_inc;
          pulse_d     = ~def_q;
          state_d     = ACTIVE;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_WIDTH'(1);
          pulse_d   = def_q;
        end
      end

      default: begin
        pulse_d = def_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, latched configuration, counters and registered outputs
  always_ff @(posedge io_clk or negedge io_rstn) begin
    if (!io_rstn) begin
      state_q     <= IDLE;
      width_q     <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      def_q       <= 1'b0;
      act_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      num_q       <= num_d;
      def_q       <= def_d;
      act_cnt_q   <= act_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign io_pulsePort = pulse_q;
  assign io_busy      = busy_q;
  assign io_done      = done_q;
  assign io_pulseCnt  = pulse_cnt_q;

endmodule : pulse_gen

`default_nettype wire

// File: tb/tb_pulse_gen.sv
// ============================================================================
// Module      : tb_pulse_gen
// Description : Directed self-checking bench for pulse_gen. Inputs change and
//               outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_gen;

  logic        io_clk = 1'b0;
  logic        io_rstn = 1'b0;
  logic        io_start = 1'b0;
  logic        io_stop = 1'b0;
  logic        io_defaultLevel_Pulse = 1'b0;
  logic [31:0] io_pulseWidth = '0;
  logic [31:0] io_pulsePeriod = '0;
  logic [31:0] io_pulseNum = '0;
`ifdef PULSE_GEN_EXT_TRIG_EN
  logic        io_extTrig = 1'b0;
`endif
  logic        io_pulsePort;
  logic        io_busy;
  logic        io_done;
  logic [31:0] io_pulseCnt;

  bit clk_en = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  pulse_gen #(.CNT_WIDTH(32)) dut (
    .io_clk                (io_clk),
    .io_rstn               (io_rstn),
    .io_start              (io_start),
    .io_stop               (io_stop),
    .io_defaultLevel_Pulse (io_defaultLevel_Pulse),
    .io_pulseWidth         (io_pulseWidth),
    .io_pulsePeriod        (io_pulsePeriod),
    .io_pulseNum           (io_pulseNum),
`ifdef PULSE_GEN_EXT_TRIG_EN
    .io_extTrig            (io_extTrig),
`endif
    .io_pulsePort          (io_pulsePort),
    .io_busy               (io_busy),
    .io_done               (io_done),
    .io_pulseCnt           (io_pulseCnt)
  );

  // Gateable clock so the async-reset test can freeze it
  always begin
    #5;
    if (clk_en) io_clk = ~io_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge io_clk);
  endtask

  // Program config and pulse start for one cycle; returns at cycle N+1
  task automatic apply_start(input logic dl, input logic [31:0] w, input logic [31:0] p,
                             input logic [31:0] n);
    io_defaultLevel_Pulse = dl;
    io_pulseWidth  = w;
    io_pulsePeriod = p;
    io_pulseNum    = n;
    io_start = 1'b1;
    cyc();
    io_start = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    n_tests++;
    if ({io_pulsePort, io_busy, io_done} !== 3'b000 || io_pulseCnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state got port=%b busy=%b done=%b cnt=%0d exp 0/0/0/0",
               io_pulsePort, io_busy, io_done, io_pulseCnt);
    end
    io_rstn = 1'b1;
    cyc();
    io_defaultLevel_Pulse = 1'b1;
    #1;
    n_tests++;
    if (io_pulsePort !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_lag got %b exp 0", io_pulsePort);
    end
    cyc();
    n_tests++;
    if (io_pulsePort !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_follow got %b exp 1", io_pulsePort);
    end
    io_defaultLevel_Pulse = 1'b0;
    cyc();
    n_tests++;
    if (io_pulsePort !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_return got %b exp 0", io_pulsePort);
    end
  endtask

  // width=3 period=5 num=2; optionally retries start mid-train and
  // start+stop together once idle, both of which must be ignored
  task automatic run_basic(input bit with_ignore);
    logic        exp_p, exp_b, exp_d;
    logic [31:0] exp_c;
    apply_start(1'b0, 32'd3, 32'd5, 32'd2);
    for (int k = 1; k <= 14; k++) begin
      exp_p = ((k >= 1) && (k <= 3)) || ((k >= 6) && (k <= 8));
      exp_b = (k <= 9);
      exp_d = (k == 10);
      exp_c = (k < 6) ? 32'd1 : 32'd2;
      n_tests++;
      if (io_pulsePort !== exp_p) begin
        n_fail++;
        $display("FAIL basic_port ign=%0d k=%0d got %b exp %b", with_ignore, k, io_pulsePort, exp_p);
      end
      n_tests++;
      if (io_busy !== exp_b) begin
        n_fail++;
        $display("FAIL basic_busy ign=%0d k=%0d got %b exp %b", with_ignore, k, io_busy, exp_b);
      end
      n_tests++;
      if (io_done !== exp_d) begin
        n_fail++;
        $display("FAIL basic_done ign=%0d k=%0d got %b exp %b", with_ignore, k, io_done, exp_d);
      end
      n_tests++;
      if (io_pulseCnt !== exp_c) begin
        n_fail++;
        $display("FAIL basic_cnt ign=%0d k=%0d got %0d exp %0d", with_ignore, k, io_pulseCnt, exp_c);
      end
      if (with_ignore && k == 2) begin
        io_pulseWidth  = 32'd9;
        io_pulsePeriod = 32'd20;
        io_pulseNum    = 32'd5;
        io_start = 1'b1;
      end
      if (with_ignore && k == 11) begin
        io_start = 1'b1;
        io_stop  = 1'b1;
      end
      cyc();
      io_start = 1'b0;
      io_stop  = 1'b0;
    end
  endtask

  task automatic test_basic();
    run_basic(1'b0);
  endtask

  task automatic test_ignore();
    run_basic(1'b1);
  endtask

  task automatic test_clamp();
    logic exp_p, exp_b, exp_d;
    apply_start(1'b0, 32'd0, 32'd0, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      exp_p = (k <= 2);
      exp_b = (k <= 2);
      exp_d = (k == 3);
      n_tests++;
      if (io_pulsePort !== exp_p || io_busy !== exp_b || io_done !== exp_d) begin
        n_fail++;
        $display("FAIL clamp k=%0d got port=%b busy=%b done=%b exp %b/%b/%b",
                 k, io_pulsePort, io_busy, io_done, exp_p, exp_b, exp_d);
      end
      n_tests++;
      if (io_pulseCnt !== 32'd1) begin
        n_fail++;
        $display("FAIL clamp_cnt k=%0d got %0d exp 1", k, io_pulseCnt);
      end
      cyc();
    end
  endtask

  // default=1 width=4 period=10 continuous; config changes mid-train are
  // ignored; stop after the third pulse has started
  task automatic test_stop_continuous();
    logic        exp_p;
    logic [31:0] exp_c;
    io_defaultLevel_Pulse = 1'b1;
    cyc();
    cyc();
    apply_start(1'b1, 32'd4, 32'd10, 32'd0);
    io_defaultLevel_Pulse = 1'b0;
    io_pulseWidth  = 32'd7;
    io_pulsePeriod = 32'd3;
    for (int k = 1; k <= 25; k++) begin
      exp_p = (((k - 1) % 10) >= 4);
      exp_c = 32'((k - 1) / 10 + 1);
      n_tests++;
      if (io_pulsePort !== exp_p || io_busy !== 1'b1 || io_done !== 1'b0) begin
        n_fail++;
        $display("FAIL cont k=%0d got port=%b busy=%b done=%b exp %b/1/0",
                 k, io_pulsePort, io_busy, io_done, exp_p);
      end
      n_tests++;
      if (io_pulseCnt !== exp_c) begin
        n_fail++;
        $display("FAIL cont_cnt k=%0d got %0d exp %0d", k, io_pulseCnt, exp_c);
      end
      if (k == 20) io_defaultLevel_Pulse = 1'b1;
      if (k == 25) io_stop = 1'b1;
      cyc();
      io_stop = 1'b0;
    end
    for (int k = 26; k <= 28; k++) begin
      n_tests++;
      if (io_pulsePort !== 1'b1 || io_busy !== 1'b0 || io_done !== 1'b0 || io_pulseCnt !== 32'd3) begin
        n_fail++;
        $display("FAIL after_stop k=%0d got port=%b busy=%b done=%b cnt=%0d exp 1/0/0/3",
                 k, io_pulsePort, io_busy, io_done, io_pulseCnt);
      end
      cyc();
    end
    io_defaultLevel_Pulse = 1'b0;
    cyc();
  endtask

  // Stop in the same cycle the final pulse would complete: no done
  task automatic test_stop_at_end();
    apply_start(1'b0, 32'd2, 32'd3, 32'd1);
    cyc();
    n_tests++;
    if (io_pulsePort !== 1'b1 || io_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL end_pre got port=%b busy=%b exp 1/1", io_pulsePort, io_busy);
    end
    io_stop = 1'b1;
    cyc();
    io_stop = 1'b0;
    n_tests++;
    if (io_pulsePort !== 1'b0 || io_busy !== 1'b0 || io_done !== 1'b0 || io_pulseCnt !== 32'd1) begin
      n_fail++;
      $display("FAIL stop_wins got port=%b busy=%b done=%b cnt=%0d exp 0/0/0/1",
               io_pulsePort, io_busy, io_done, io_pulseCnt);
    end
    cyc();
    n_tests++;
    if (io_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_wins_late got done=%b exp 0", io_done);
    end
  endtask

  task automatic test_async_reset();
    apply_start(1'b0, 32'd5, 32'd8, 32'd0);
    cyc();
    n_tests++;
    if (io_pulsePort !== 1'b1 || io_busy !== 1'b1 || io_pulseCnt !== 32'd1) begin
      n_fail++;
      $display("FAIL areset_pre got port=%b busy=%b cnt=%0d exp 1/1/1",
               io_pulsePort, io_busy, io_pulseCnt);
    end
    clk_en = 1'b0;
    #2;
    io_rstn = 1'b0;
    #1;
    n_tests++;
    if (io_pulsePort !== 1'b0 || io_busy !== 1'b0 || io_pulseCnt !== 32'd0 || io_done !== 1'b0) begin
      n_fail++;
      $display("FAIL areset got port=%b busy=%b done=%b cnt=%0d exp 0/0/0/0",
               io_pulsePort, io_busy, io_done, io_pulseCnt);
    end
    #2;
    io_rstn = 1'b1;
    #1;
    clk_en = 1'b1;
    cyc();
    n_tests++;
    if (io_pulsePort !== 1'b0 || io_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release got port=%b busy=%b exp 0/0", io_pulsePort, io_busy);
    end
  endtask

`ifdef PULSE_GEN_EXT_TRIG_EN
  // Pin rises mid-cycle c; pulse high in cycles c+4, c+5; held pin never retriggers
  task automatic test_ext_trig();
    logic exp_p, exp_d;
    io_defaultLevel_Pulse = 1'b0;
    io_pulseWidth  = 32'd2;
    io_pulsePeriod = 32'd3;
    io_pulseNum    = 32'd1;
    #2;
    io_extTrig = 1'b1;
    for (int m = 1; m <= 20; m++) begin
      cyc();
      exp_p = (m == 4) || (m == 5);
      exp_d = (m == 6);
      n_tests++;
      if (io_pulsePort !== exp_p || io_done !== exp_d) begin
        n_fail++;
        $display("FAIL ext_trig m=%0d got port=%b done=%b exp %b/%b",
                 m, io_pulsePort, io_done, exp_p, exp_d);
      end
    end
    io_extTrig = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stop_continuous();
    test_ignore();
    test_stop_at_end();
    test_async_reset();
`ifdef PULSE_GEN_EXT_TRIG_EN
    test_ext_trig();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pulse_gen

`default_nettype wire
